// File: rtl/game_sequencer.sv
// Round/level sequencer for frogger: turns collision levels into per-round events,
// holds the playfield in reset for a respawn pause, tracks level, lives and speed bonus.
// Ports: clk, reset (sync, active-high); death_collision, win_collision, restart_request in;
// round_reset, current_level, lives, game_over, level_up, life_lost, speed_bonus out (all registered).
module game_sequencer #(
  parameter int PAUSE_CYCLES = 25_000_000,
  parameter int START_LIVES  = 3,
  parameter int MAX_LEVEL    = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       death_collision,
  input  logic       win_collision,
  input  logic       restart_request,
  output logic       round_reset,
  output logic [3:0] current_level,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       level_up,
  output logic       life_lost,
  output logic [1:0] speed_bonus
);

  localparam int TW = $clog2(PAUSE_CYCLES + 1);
  localparam logic [TW-1:0] LAST_TICK   = TW'(PAUSE_CYCLES - 1);
  localparam logic [3:0]    MAX_LVL     = 4'(MAX_LEVEL);
  localparam logic [1:0]    LIVES_INIT  = 2'(START_LIVES);

  typedef enum logic [1:0] {
    RESPAWN   = 2'd0,
    PLAY      = 2'd1,
    GAME_OVER = 2'd2
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [3:0]    next_level;

  function automatic logic [1:0] bonus_of(input logic [3:0] lvl);
    if (lvl >= 4'd6)      return 2'd2;
    else if (lvl >= 4'd3) return 2'd1;
    else                  return 2'd0;
  endfunction

  assign next_level = (current_level == MAX_LVL) ? 4'd0 : current_level + 4'd1;

  // Restart behaves exactly like reset; holding it pins the timer at 0 so the
  // pause only begins counting once it is released.
  always_ff @(posedge clk) begin
    if (reset || restart_request) begin
      state         <= RESPAWN;
      timer         <= '0;
      current_level <= 4'd0;
      lives         <= LIVES_INIT;
      round_reset   <= 1'b1;
      game_over     <= 1'b0;
      level_up      <= 1'b0;
      life_lost     <= 1'b0;
      speed_bonus   <= 2'd0;
    end else begin
      level_up  <= 1'b0;
      life_lost <= 1'b0;
      case (state)
        RESPAWN: begin
          // Timer reaching LAST_TICK means PAUSE_CYCLES cycles of round_reset
          // have elapsed since entry, so release the playfield on this edge.
          if (timer == LAST_TICK) begin
            state       <= PLAY;
            timer       <= '0;
            round_reset <= 1'b0;
          end else begin
            timer       <= timer + TW'(1);
            round_reset <= 1'b1;
          end
        end
        PLAY: begin
          if (win_collision) begin
            // Win outranks a simultaneous death.
            level_up      <= 1'b1;
            current_level <= next_level;
            speed_bonus   <= bonus_of(next_level);
            state         <= RESPAWN;
            timer         <= '0;
            round_reset   <= 1'b1;
          end else if (death_collision && lives != 2'd0) begin
            life_lost   <= 1'b1;
            lives       <= lives - 2'd1;
            timer       <= '0;
            round_reset <= 1'b1;
            if (lives == 2'd1) begin
              state     <= GAME_OVER;
              game_over <= 1'b1;
            end else begin
              state     <= RESPAWN;
            end
          end
        end
        GAME_OVER: begin
          round_reset <= 1'b1;
          game_over   <= 1'b1;
        end
        default: begin
          state       <= RESPAWN;
          timer       <= '0;
          round_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with PAUSE_CYCLES=4, START_LIVES=3, MAX_LEVEL=9.
// Inputs change right after a sampling point; outputs are sampled 1 ns after each rising edge.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       death_collision = 1'b0;
  logic       win_collision = 1'b0;
  logic       restart_request = 1'b0;
  logic       round_reset;
  logic [3:0] current_level;
  logic [1:0] lives;
  logic       game_over;
  logic       level_up;
  logic       life_lost;
  logic [1:0] speed_bonus;

  int n_vec = 0;
  int n_bad = 0;

  game_sequencer #(
    .PAUSE_CYCLES(4),
    .START_LIVES (3),
    .MAX_LEVEL   (9)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .death_collision(death_collision),
    .win_collision  (win_collision),
    .restart_request(restart_request),
    .round_reset    (round_reset),
    .current_level  (current_level),
    .lives          (lives),
    .game_over      (game_over),
    .level_up       (level_up),
    .life_lost      (life_lost),
    .speed_bonus    (speed_bonus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until round_reset drops (bounded) and checks how many edges it took.
  task automatic wait_play(input string tag, input int exp_steps);
    int n = 0;
    while (round_reset && n < 50) begin
      step();
      n++;
    end
    check(tag, n, exp_steps);
  endtask

  int exp_lvl[10]   = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0};
  int exp_bonus[10] = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 0};

  initial begin
    // 1: reset values and first pause
    step();
    check("rst_round_reset", round_reset, 1);
    check("rst_level", current_level, 0);
    check("rst_lives", lives, 3);
    check("rst_game_over", game_over, 0);
    check("rst_level_up", level_up, 0);
    check("rst_life_lost", life_lost, 0);
    check("rst_bonus", speed_bonus, 0);
    reset = 1'b0;
    wait_play("first_pause", 4);
    check("play_level", current_level, 0);
    check("play_lives", lives, 3);
    check("play_game_over", game_over, 0);

    // 2: ten wins, level 1..9 then wrap to 0
    for (int k = 0; k < 10; k++) begin
      win_collision = 1'b1;
      step();
      win_collision = 1'b0;
      check($sformatf("win%0d_level_up", k), level_up, 1);
      check($sformatf("win%0d_level", k), current_level, exp_lvl[k]);
      check($sformatf("win%0d_bonus", k), speed_bonus, exp_bonus[k]);
      check($sformatf("win%0d_lives", k), lives, 3);
      check($sformatf("win%0d_round_reset", k), round_reset, 1);
      step();
      check($sformatf("win%0d_pulse_drop", k), level_up, 0);
      wait_play($sformatf("win%0d_pause", k), 3);
    end

    // 4: simultaneous win and death -> win only
    win_collision = 1'b1;
    death_collision = 1'b1;
    step();
    win_collision = 1'b0;
    death_collision = 1'b0;
    check("both_level_up", level_up, 1);
    check("both_life_lost", life_lost, 0);
    check("both_lives", lives, 3);
    check("both_level", current_level, 1);
    wait_play("both_pause", 4);

    // 3: three deaths to game over, then collisions ignored
    for (int d = 0; d < 3; d++) begin
      death_collision = 1'b1;
      step();
      death_collision = 1'b0;
      check($sformatf("death%0d_life_lost", d), life_lost, 1);
      check($sformatf("death%0d_lives", d), lives, 2 - d);
      check($sformatf("death%0d_game_over", d), game_over, (d == 2) ? 1 : 0);
      check($sformatf("death%0d_level", d), current_level, 1);
      if (d < 2) wait_play($sformatf("death%0d_pause", d), 4);
    end
    win_collision = 1'b1;
    death_collision = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("go%0d_level", i), current_level, 1);
      check($sformatf("go%0d_lives", i), lives, 0);
      check($sformatf("go%0d_game_over", i), game_over, 1);
      check($sformatf("go%0d_pulses", i), {level_up, life_lost}, 0);
      check($sformatf("go%0d_round_reset", i), round_reset, 1);
    end
    win_collision = 1'b0;
    death_collision = 1'b0;

    // 6: restart held 10 cycles from game over
    restart_request = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("rs%0d_round_reset", i), round_reset, 1);
      check($sformatf("rs%0d_game_over", i), game_over, 0);
    end
    restart_request = 1'b0;
    check("rs_level", current_level, 0);
    check("rs_lives", lives, 3);
    check("rs_bonus", speed_bonus, 0);
    wait_play("rs_pause", 4);

    // 5: held death counts once per PLAY entry
    begin
      int pulses = 0;
      death_collision = 1'b1;
      for (int i = 0; i < 6; i++) begin
        step();
        pulses += int'(life_lost);
        if (i == 4) check("held_first_play", round_reset, 0);
        if (i == 4) check("held_no_recount", pulses, 1);
      end
      death_collision = 1'b0;
      check("held_pulses", pulses, 2);
      check("held_lives", lives, 1);
      step();
      check("held_pulse_drop", life_lost, 0);
      wait_play("held_pause", 3);
    end

    // Reset in the same edge as a win cancels the event
    win_collision = 1'b1;
    reset = 1'b1;
    step();
    win_collision = 1'b0;
    reset = 1'b0;
    check("rstwin_level_up", level_up, 0);
    check("rstwin_level", current_level, 0);
    check("rstwin_lives", lives, 3);
    check("rstwin_round_reset", round_reset, 1);
    wait_play("rstwin_pause", 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
